// File: rtl/nine_segment_pkg.sv
// Shared types and glyph patterns for the nine-segment message path.
// Pattern bit index is row*3+col, with row 0 at the top and col 0 at the left.
package nine_segment_pkg;

  typedef logic [8:0] segment_t;
  typedef logic [3:0] glyph_code_t;

  // Type of the downstream converter's segments port.
  typedef segment_t converter_segments_t;

  localparam segment_t GLYPH_BLANK    = 9'b000000000;
  localparam segment_t GLYPH_FULL     = 9'b111111111;
  localparam segment_t GLYPH_CENTRE   = 9'b000010000;
  localparam segment_t GLYPH_PLUS     = 9'b010111010;
  localparam segment_t GLYPH_X        = 9'b101010101;
  localparam segment_t GLYPH_FRAME    = 9'b111101111;
  localparam segment_t GLYPH_ROW_TOP  = 9'b000000111;
  localparam segment_t GLYPH_ROW_MID  = 9'b000111000;
  localparam segment_t GLYPH_ROW_BOT  = 9'b111000000;
  localparam segment_t GLYPH_COL_LEFT = 9'b001001001;
  localparam segment_t GLYPH_COL_MID  = 9'b010010010;
  localparam segment_t GLYPH_COL_RGT  = 9'b100100100;
  localparam segment_t GLYPH_DIAG     = 9'b100010001;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } seq_state_t;

endpackage

// File: rtl/nine_segment_glyph_decoder.sv
// Combinational lookup from a 4-bit glyph code to its 3x3 segment pattern.
module nine_segment_glyph_decoder
  import nine_segment_pkg::*;
(
  input  glyph_code_t code,
  output segment_t    pattern
);

  // Reserved codes D-F fall through to blank.
  always_comb begin
    pattern = GLYPH_BLANK;
    case (code)
      4'h1:    pattern = GLYPH_FULL;
      4'h2:    pattern = GLYPH_CENTRE;
      4'h3:    pattern = GLYPH_PLUS;
      4'h4:    pattern = GLYPH_X;
      4'h5:    pattern = GLYPH_FRAME;
      4'h6:    pattern = GLYPH_ROW_TOP;
      4'h7:    pattern = GLYPH_ROW_MID;
      4'h8:    pattern = GLYPH_ROW_BOT;
      4'h9:    pattern = GLYPH_COL_LEFT;
      4'hA:    pattern = GLYPH_COL_MID;
      4'hB:    pattern = GLYPH_COL_RGT;
      4'hC:    pattern = GLYPH_DIAG;
      default: pattern = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/nine_segment_message_sequencer.sv
// Buffers a short glyph message and plays it as a looping sequence of
// held glyphs with optional blank gaps, feeding the nine-segment converter.
module nine_segment_message_sequencer
  import nine_segment_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 3000,
  parameter int GAP_CYCLES  = 300
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  glyph_code_t                wr_code,
  output logic                       wr_ready,
  input  logic                       clear,
  input  logic                       run,
  output converter_segments_t        segments,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       wrap
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(DEPTH);
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  seq_state_t      state, state_next;
  logic [IW-1:0]   idx, idx_next, idx_adv;
  logic [CW-1:0]   idx_plus;
  logic [TW-1:0]   timer, timer_next;
  logic            wrap_next;
  logic            blank_next;
  logic            wr_fire;
  glyph_code_t     msg_buf [DEPTH];
  segment_t        rd_pattern;

  assign wr_ready = !reset && !clear && (count < CW'(DEPTH));
  assign wr_fire  = wr_valid && wr_ready;

  // Next glyph in the loop, wrapping on the count seen this cycle.
  always_comb begin
    idx_plus = CW'(idx) + CW'(1);
    idx_adv  = (idx_plus >= count) ? '0 : IW'(idx_plus);
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    timer_next = timer;
    wrap_next  = 1'b0;
    blank_next = 1'b1;
    if (clear) begin
      state_next = IDLE;
      idx_next   = '0;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          idx_next = '0;
          if (run && count != '0) begin
            state_next = SHOW;
            timer_next = HOLD_LOAD;
            wrap_next  = 1'b1;
            blank_next = 1'b0;
          end
        end
        SHOW: begin
          if (!run) begin
            state_next = IDLE;
            idx_next   = '0;
          end else if (timer != '0) begin
            timer_next = timer - TW'(1);
            blank_next = 1'b0;
          end else if (GAP_CYCLES > 0) begin
            state_next = GAP;
            timer_next = GAP_LOAD;
          end else begin
            idx_next   = idx_adv;
            timer_next = HOLD_LOAD;
            wrap_next  = (idx_adv == '0);
            blank_next = 1'b0;
          end
        end
        GAP: begin
          if (!run) begin
            state_next = IDLE;
            idx_next   = '0;
          end else if (timer != '0) begin
            timer_next = timer - TW'(1);
          end else begin
            state_next = SHOW;
            idx_next   = idx_adv;
            timer_next = HOLD_LOAD;
            wrap_next  = (idx_adv == '0);
            blank_next = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Decode the glyph that will be on display after the coming edge.
  nine_segment_glyph_decoder u_decoder (
    .code    (msg_buf[idx_next]),
    .pattern (rd_pattern)
  );

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      msg_buf[IW'(count)] <= wr_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      timer    <= '0;
      segments <= GLYPH_BLANK;
      wrap     <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      timer    <= timer_next;
      segments <= blank_next ? GLYPH_BLANK : rd_pattern;
      wrap     <= wrap_next;
      if (clear) begin
        count <= '0;
      end else if (wr_fire) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: doc/nine_segment_message_sequencer.md
# nine_segment_message_sequencer

Upstream stage of `nine_segment_to_six_pin`. It buffers a short message of 4-bit glyph codes and decodes each code to a 9-bit segment pattern. It then plays the message as a looping sequence on `segments`, holding each glyph for a fixed number of cycles with an optional blank gap between glyphs. The `segments` output connects directly to the converter's `segments` input on the same `clk`.

## Interface
- `DEPTH`, default 8: message buffer capacity in glyphs, must be at least 2.
- `HOLD_CYCLES`, default 3000: cycles each glyph is shown. Must be at least 1 and should be a multiple of 3, so the converter completes whole 3-row scans.
- `GAP_CYCLES`, default 300: blank cycles after each glyph. A value of 0 means there is no gap.
- `clk` in 1: single clock. One clock, shared with the converter.
- `reset` in 1: reset is synchronous and active-high.
- `wr_valid` in 1: a glyph code is offered.
- `wr_code` in 4: the offered glyph code.
- `wr_ready` out 1: the buffer accepts a write this cycle.
- `clear` in 1: empties the buffer and stops playback.
- `run` in 1: level input; high means play, low means idle.
- `segments` out 9: registered pattern. Bit index is row*3+col, where row 0 is the top row and col 0 is the left column.
- `count` out clog2(DEPTH+1): number of glyphs stored.
- `wrap` out 1: one-cycle pulse on the first cycle glyph 0 is shown.

## Operation
- Glyph decode: `0` is blank 000000000.
- Solid and symbol glyphs: `1` full 111111111, `2` centre 000010000, `3` plus 010111010, `4` X 101010101, `5` frame 111101111.
- Row glyphs: `6` top 000000111, `7` middle 000111000, `8` bottom 111000000.
- Column glyphs: `9` left 001001001, `A` middle 010010010, `B` right 100100100.
- Diagonal glyphs: `C` diagonal 100010001. Codes `D`–`F` are reserved and decode to blank.
- Write: a write is accepted when `wr_valid && wr_ready`. The code is stored at `buf[count]` and `count` increments on the same edge.
- `wr_ready = !reset && !clear && count < DEPTH`.
- Writes during playback are allowed. The new glyph is appended and joins the loop.
- FSM states are IDLE, SHOW and GAP.
- In IDLE, `segments` = 0 and `idx` = 0.
- IDLE to SHOW happens when `run && count > 0`. Set `idx` = 0, load the hold counter, and raise `wrap`.
- SHOW drives `segments` = decode(`buf[idx]`) for exactly HOLD_CYCLES cycles.
- At the end of SHOW, go to GAP if GAP_CYCLES > 0. Otherwise advance directly.
- GAP drives `segments` = 0 for exactly GAP_CYCLES cycles, then advances.
- Advance sets `idx` to `idx+1`, or to 0 if `idx+1 >= count`, where `count` is sampled on the advance cycle. The FSM enters SHOW, and `wrap` pulses when `idx` becomes 0.
- If `run` is low in SHOW or GAP, the FSM goes to IDLE on the next edge: `segments` = 0 and `idx` = 0.
- If `clear` is high, on the next edge `count` = 0, state = IDLE, `segments` = 0, and buffer contents are don't-care.
- `clear` wins over a simultaneous write and over `run`.
- If `count` = 1, the same glyph repeats, separated by gaps. `wrap` pulses every HOLD_CYCLES+GAP_CYCLES cycles.

## Timing
- Reset values: `segments` = 0, `count` = 0, `wrap` = 0, `wr_ready` = 0 while `reset` is high, state = IDLE, `idx` = 0.
- `segments`, `wrap`, `count` and state are all registered. They update on the same edge.
- Latency: if `run` is first sampled high at edge N with `count` > 0, glyph 0 appears from edge N+1.
- Write latency: a write accepted at edge N shows `count` incremented from edge N+1. That glyph can be shown from edge N+1 if it is the next glyph selected.
- Period: the loop period is `count`×(HOLD_CYCLES+GAP_CYCLES) cycles.
- `wr_ready` is combinational from `clear`, `reset` and `count`.
- Reset mid-operation produces the same result as clear, with `wr_ready` held low.

## Structure
- Package `nine_segment_pkg` holds:
  - `segment_t` (logic [8:0]);
  - `glyph_code_t` (logic [3:0]);
  - the glyph pattern localparams;
  - the FSM state enum;
  - the shared type for the converter `segments` port.
- Sub-module `nine_segment_glyph_decoder`: purely combinational, `glyph_code_t` to `segment_t`, instantiated once on `buf[idx]`.
- Buffer: a register array indexed by `count` (write) and `idx` (read); no FIFO pop.

## Test plan
Bench parameters are DEPTH=4, HOLD_CYCLES=3, GAP_CYCLES=1. The converter is instantiated downstream.
- Reset check: assert `reset` for 2 cycles. Expect `segments` = 0, `count` = 0, `wr_ready` = 0, then `wr_ready` = 1 after release.
- Basic playback: write `2`, `3`, then raise `run`.
  - `segments` shows 000010000 for 3 cycles, then 0 for 1 cycle, then 010111010 for 3 cycles, then 0 for 1 cycle, then repeats.
  - `wrap` pulses every 8 cycles.
  - The converter shows rows 010 / cols 101 on its middle-row phase while glyph `2` is shown.
- Buffer full: write `1`, `4`, `6`, `8`, then hold `wr_valid` with code `9`. Expect `wr_ready` = 0, `count` = 4, and code `9` never appears.
- Append during run: start with code `2` only, then write `4` during the GAP. The next loop shows 000010000 then 101010101, and `count` = 2.
- Clear mid-SHOW while a write is offered the same cycle: next edge gives `segments` = 0, `count` = 0, IDLE, and the write is dropped.
- Stop and restart: with `count` = 1, drop `run` mid-SHOW, then raise it after 5 cycles. `segments` = 0 while idle, then glyph 0 is shown one cycle after `run` with `wrap` = 1. Repeat with GAP_CYCLES=0 and check glyphs are back-to-back with no blank.
